// File: rtl/aes_inv_cipher_if.sv
// Handshake, key-store and result bundle for the AES-128 inverse cipher.
// Optional feature macro: AES_DEC_ABORT_EN adds the 'abort' request line.
interface aes_inv_cipher_if #(
    parameter int unsigned KIDX_W = 4
);
    logic              start;
    logic [127:0]      cipher_text;
    logic              ready;
    logic              busy;
    logic [KIDX_W-1:0] rk_index;
    logic [127:0]      rk_data;
    logic [127:0]      plain_text;
    logic              pt_valid;
`ifdef AES_DEC_ABORT_EN
    logic              abort;

    modport master (
        output start, cipher_text, rk_data, abort,
        input  ready, busy, rk_index, plain_text, pt_valid
    );
    modport slave (
        input  start, cipher_text, rk_data, abort,
        output ready, busy, rk_index, plain_text, pt_valid
    );
`else
    modport master (
        output start, cipher_text, rk_data,
        input  ready, busy, rk_index, plain_text, pt_valid
    );
    modport slave (
        input  start, cipher_text, rk_data,
        output ready, busy, rk_index, plain_text, pt_valid
    );
`endif
endinterface

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher, one round per clock, round keys 10..0 read
// from a synchronous-read key store. Synchronous active-high reset.
// Optional feature macro: AES_DEC_ABORT_EN (busy-time cancel via bus.abort).
module aes_inv_cipher #(
    parameter int unsigned NR     = 10,
    parameter int unsigned KIDX_W = 4
) (
    input logic              clk,
    input logic              rst,
    aes_inv_cipher_if.slave  bus
);
    typedef enum logic [2:0] {StIdle, StFetch, StInit, StRound, StLast, StDone} state_e;

    // Inverse S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] InvSbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return InvSbox[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    // Sixteen parallel S-box lookups.
    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
        end
        return o;
    endfunction

    // Circulant [0e 0b 0d 09] per column, products built from x2/x4/x8 chains.
    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        logic [7:0]   m9 [4];
        logic [7:0]   mb [4];
        logic [7:0]   md [4];
        logic [7:0]   me [4];
        logic [7:0]   x2, x4, x8;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = s[127 - 8 * (4 * c + r) -: 8];
                x2    = xtime(a[r]);
                x4    = xtime(x2);
                x8    = xtime(x4);
                m9[r] = x8 ^ a[r];
                mb[r] = x8 ^ x2 ^ a[r];
                md[r] = x8 ^ x4 ^ a[r];
                me[r] = x8 ^ x4 ^ x2;
            end
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = me[r] ^ mb[(r + 1) % 4] ^
                                                md[(r + 2) % 4] ^ m9[(r + 3) % 4];
            end
        end
        return o;
    endfunction

    state_e            state_q, state_d;
    logic [127:0]      st_q, st_d;
    logic [127:0]      pt_q, pt_d;
    logic [KIDX_W-1:0] rk_idx_q, rk_idx_d;
    logic [3:0]        rnd_q, rnd_d;
    logic              ready_w;
    logic [127:0]      last_w;

    assign ready_w        = (state_q == StIdle) || (state_q == StDone);
    assign last_w         = inv_sub_bytes(inv_shift_rows(st_q)) ^ bus.rk_data;
    assign bus.ready      = ready_w;
    assign bus.busy       = !ready_w;
    assign bus.rk_index   = rk_idx_q;
    assign bus.plain_text = pt_q;
    assign bus.pt_valid   = (state_q == StDone);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            st_q     <= '0;
            pt_q     <= '0;
            rk_idx_q <= '0;
            rnd_q    <= '0;
        end else begin
            state_q  <= state_d;
            st_q     <= st_d;
            pt_q     <= pt_d;
            rk_idx_q <= rk_idx_d;
            rnd_q    <= rnd_d;
        end
    end

    // Next-state and round datapath; key index runs one step ahead of use
    // because the key store answers a cycle after the address changes.
    always_comb begin
        state_d  = state_q;
        st_d     = st_q;
        pt_d     = pt_q;
        rk_idx_d = rk_idx_q;
        rnd_d    = rnd_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    st_d     = bus.cipher_text;
                    rk_idx_d = KIDX_W'(NR);
                    state_d  = StFetch;
                end
            end
            StFetch: begin
                rk_idx_d = rk_idx_q - KIDX_W'(1);
                state_d  = StInit;
            end
            StInit: begin
                st_d     = st_q ^ bus.rk_data;
                rk_idx_d = rk_idx_q - KIDX_W'(1);
                rnd_d    = 4'(NR - 1);
                state_d  = StRound;
            end
            StRound: begin
                st_d     = inv_mix_columns(inv_sub_bytes(inv_shift_rows(st_q)) ^ bus.rk_data);
                rk_idx_d = (rk_idx_q == '0) ? '0 : rk_idx_q - KIDX_W'(1);
                rnd_d    = rnd_q - 4'd1;
                if (rnd_q == 4'd1) begin
                    state_d = StLast;
                end
            end
            StLast: begin
                st_d    = last_w;
                pt_d    = last_w;
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
`ifdef AES_DEC_ABORT_EN
        // Cancel drops the block; the previous result stays visible.
        if (bus.abort && !ready_w) begin
            state_d  = StIdle;
            rk_idx_d = '0;
            pt_d     = pt_q;
        end
`endif
    end
endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed bench for aes_inv_cipher with a sync-read round-key ROM and a
// plaintext scoreboard popped on each pt_valid pulse.
module tb_aes_inv_cipher;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] JUNK = 128'hdeadbeef0badf00dcafef00d12345678;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   cyc;
    int   npulse;
    int   pv_first;
    int   pv_last;
    logic [127:0] exp_q[$];

    aes_inv_cipher_if bus ();

    aes_inv_cipher dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] rkey(input logic [3:0] i);
        case (i)
            4'd0:    return 128'h000102030405060708090a0b0c0d0e0f;
            4'd1:    return 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
            4'd2:    return 128'hb692cf0b643dbdf1be9bc5006830b3fe;
            4'd3:    return 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
            4'd4:    return 128'h47f7f7bc95353e03f96c32bcfd058dfd;
            4'd5:    return 128'h3caaa3e8a99f9deb50f3af57adf622aa;
            4'd6:    return 128'h5e390f7df7a69296a7553dc10aa31f6b;
            4'd7:    return 128'h14f9701ae35fe28c440adf4d4ea9c026;
            4'd8:    return 128'h47438735a41c65b9e016baf4aebf7ad2;
            4'd9:    return 128'h549932d1f08557681093ed9cbe2c974e;
            4'd10:   return K10;
            default: return 128'h0;
        endcase
    endfunction

    // Key store: data valid one cycle after the address.
    always @(posedge clk) bus.rk_data <= rkey(bus.rk_index);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Advance one clock and sample #1 later; retire a scoreboard entry on pt_valid.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.pt_valid === 1'b1) begin
            npulse++;
            if (pv_first == 0) pv_first = cyc;
            pv_last = cyc;
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL spurious_pt_valid: observed pulse at cycle %0d expected none", cyc);
            end
            if (exp_q.size() != 0) chk("plain_text", bus.plain_text, exp_q.pop_front());
        end
    endtask

    task automatic begin_block(input logic [127:0] ct, input logic [127:0] pt);
        bus.cipher_text = ct;
        bus.start       = 1'b1;
        exp_q.push_back(pt);
        cyc      = 0;
        pv_first = 0;
        pv_last  = 0;
        npulse   = 0;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_decrypt(input string tag);
        begin_block(CT, PT);
        while (cyc < 13) tick();
        chk({tag, "_latency"}, 128'(pv_first), 128'(13));
        chk({tag, "_pulses"}, 128'(npulse), 128'(1));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        npulse      = 0;
        pv_first    = 0;
        pv_last     = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.cipher_text = '0;
`ifdef AES_DEC_ABORT_EN
        bus.abort   = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_ready", 128'(bus.ready), 128'(1));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_plain_text", bus.plain_text, 128'h0);
        chk("rst_rk_index", 128'(bus.rk_index), 128'(0));
        chk("rst_pt_valid", 128'(bus.pt_valid), 128'(0));

        // FIPS-197 vector with key-index trace and INIT sanity check.
        begin_block(CT, PT);
        while (cyc < 13) begin
            chk("t1_rk_index", 128'(bus.rk_index), 128'((cyc <= 11) ? 11 - cyc : 0));
            chk("t1_busy", 128'(bus.busy), 128'(1));
            if (cyc == 3) chk("t1_key10_state", dut.st_q, CT ^ K10);
            tick();
        end
        chk("t1_pt_valid", 128'(bus.pt_valid), 128'(1));
        chk("t1_ready_done", 128'(bus.ready), 128'(1));
        chk("t1_latency", 128'(pv_first), 128'(13));
        tick();
        chk("t1_idle_pt_valid", 128'(bus.pt_valid), 128'(0));

        // Back-to-back: start held through DONE.
        bus.cipher_text = CT;
        bus.start       = 1'b1;
        exp_q.push_back(PT);
        cyc = 0; pv_first = 0; pv_last = 0; npulse = 0;
        tick();
        while (cyc < 26) begin
            chk("t2_busy", 128'(bus.busy), 128'((cyc == 13) ? 0 : 1));
            if (cyc == 13) exp_q.push_back(PT);
            if (cyc == 14) bus.start = 1'b0;
            tick();
        end
        chk("t2_busy_done2", 128'(bus.busy), 128'(0));
        chk("t2_first", 128'(pv_first), 128'(13));
        chk("t2_second", 128'(pv_last), 128'(26));
        chk("t2_pulses", 128'(npulse), 128'(2));
        tick();

        // Start pulses while busy are ignored.
        begin_block(CT, PT);
        while (cyc < 13) begin
            chk("t3_hold", bus.plain_text, PT);
            bus.start       = (cyc == 3 || cyc == 7);
            bus.cipher_text = JUNK;
            tick();
        end
        chk("t3_latency", 128'(pv_first), 128'(13));
        repeat (15) tick();
        chk("t3_pulses", 128'(npulse), 128'(1));

        // Reset mid-block.
        begin_block(CT, PT);
        while (cyc < 6) tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        chk("t4_ready", 128'(bus.ready), 128'(1));
        chk("t4_busy", 128'(bus.busy), 128'(0));
        chk("t4_plain_text", bus.plain_text, 128'h0);
        chk("t4_rk_index", 128'(bus.rk_index), 128'(0));
        repeat (20) tick();
        chk("t4_no_pulse", 128'(npulse), 128'(0));

`ifdef AES_DEC_ABORT_EN
        // Abort mid-block keeps the previous result.
        run_decrypt("t5_pre");
        begin_block(CT, PT);
        while (cyc < 5) tick();
        bus.abort = 1'b1;
        exp_q.delete();
        tick();
        bus.abort = 1'b0;
        chk("t5_ready", 128'(bus.ready), 128'(1));
        chk("t5_busy", 128'(bus.busy), 128'(0));
        chk("t5_rk_index", 128'(bus.rk_index), 128'(0));
        chk("t5_plain_text", bus.plain_text, PT);
        repeat (20) tick();
        chk("t5_no_pulse", 128'(npulse), 128'(0));
`endif

        // Fresh block after the disturbance.
        run_decrypt("t6");
        chk("sb_empty", 128'(exp_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
